// File: rtl/branch_predictor_gshare.sv
// branch_predictor_gshare: PHT of saturating counters with bimodal or gshare indexing and GHR repair
//   clk_in            rising-edge clock
//   rst_in            synchronous reset, active-low
//   rdy_in            global ready; low pauses every register
//   query_en/pc       IF prediction request
//   data_out_en       one-cycle pulse, prediction valid
//   data_out          predicted direction (1 = taken)
//   data_out_ghr      GHR snapshot used for this prediction
//   update_en/pc      RoB resolved conditional branch
//   update_taken      actual outcome
//   update_ghr        snapshot previously returned on data_out_ghr
//   update_mispredict repair the speculative GHR (qualified by update_en)
module branch_predictor_gshare #(
    parameter int INDEX_BITS   = 6,
    parameter int COUNTER_BITS = 2,
    parameter int GHR_BITS     = 4,
    parameter int USE_GSHARE   = 1
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                query_en,
    input  logic [31:0]         query_pc,
    output logic                data_out_en,
    output logic                data_out,
    output logic [GHR_BITS-1:0] data_out_ghr,
    input  logic                update_en,
    input  logic [31:0]         update_pc,
    input  logic                update_taken,
    input  logic [GHR_BITS-1:0] update_ghr,
    input  logic                update_mispredict
);
    localparam int PHT_N = 1 << INDEX_BITS;
    localparam logic [COUNTER_BITS-1:0] CNT_MAX  = '1;
    localparam logic [COUNTER_BITS-1:0] CNT_INIT = COUNTER_BITS'((1 << (COUNTER_BITS - 1)) - 1);
    logic [COUNTER_BITS-1:0] r_pht [PHT_N];
    logic [GHR_BITS-1:0]     r_ghr;
    logic [GHR_BITS-1:0]     r_out_ghr;
    logic                    r_out_en;
    logic                    r_out;
    logic [INDEX_BITS-1:0]   w_q_idx;
    logic [INDEX_BITS-1:0]   w_u_idx;
    logic [COUNTER_BITS-1:0] w_u_cnt;
    logic [COUNTER_BITS-1:0] w_u_next;
    logic [GHR_BITS-1:0]     w_ghr_next;
    logic                    w_pred;
    logic                    w_repair;
    logic                    w_q_acc;
    logic                    w_unused;
    // GHR is zero-extended into the index; GHR_BITS never exceeds INDEX_BITS
    assign w_q_idx = query_pc[INDEX_BITS+1:2] ^ (USE_GSHARE != 0 ? INDEX_BITS'(r_ghr) : '0);
    assign w_u_idx = update_pc[INDEX_BITS+1:2] ^ (USE_GSHARE != 0 ? INDEX_BITS'(update_ghr) : '0);
    assign w_pred = r_pht[w_q_idx][COUNTER_BITS-1];
    assign w_u_cnt = r_pht[w_u_idx];
    assign w_u_next = update_taken ? (w_u_cnt == CNT_MAX ? w_u_cnt : w_u_cnt + 1'b1)
                                   : (w_u_cnt == '0 ? w_u_cnt : w_u_cnt - 1'b1);
    // a repair redirects IF, so a query in the same cycle is dropped
    assign w_repair = update_en & update_mispredict;
    assign w_q_acc = query_en & ~w_repair;
    // truncating {history, bit} to GHR_BITS shifts in the new bit, also for GHR_BITS = 1
    assign w_ghr_next = w_repair ? GHR_BITS'({update_ghr, update_taken})
                      : w_q_acc  ? GHR_BITS'({r_ghr, w_pred})
                      : r_ghr;
    assign w_unused = ^{query_pc[31:INDEX_BITS+2], query_pc[1:0],
                        update_pc[31:INDEX_BITS+2], update_pc[1:0]};
    assign data_out_en = r_out_en;
    assign data_out = r_out;
    assign data_out_ghr = r_out_ghr;
    // the query reads the pre-update counter, so the write lands after the read
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < PHT_N; i++) r_pht[i] <= CNT_INIT;
        end else if (rdy_in && update_en) begin
            r_pht[w_u_idx] <= w_u_next;
        end
    end
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_ghr <= '0;
            r_out_en <= 1'b0;
            r_out <= 1'b0;
            r_out_ghr <= '0;
        end else if (rdy_in) begin
            r_ghr <= w_ghr_next;
            r_out_en <= w_q_acc;
            if (w_q_acc) begin
                r_out <= w_pred;
                r_out_ghr <= r_ghr;
            end
        end
    end
endmodule

// File: tb/tb_branch_predictor_gshare.sv
// tb_branch_predictor_gshare: gshare and bimodal instances checked every cycle against an array model
module tb_branch_predictor_gshare;
    logic        clk = 0;
    logic        rst = 0;
    logic        rdy = 1;
    logic        qen = 0;
    logic [31:0] qpc = 0;
    logic        uen = 0;
    logic [31:0] upc = 0;
    logic        ut = 0;
    logic [3:0]  ughr = 0;
    logic        um = 0;
    logic        en_g, out_g, en_b, out_b;
    logic [3:0]  ghr_g, ghr_b;
    int          nvec = 0;
    int          nerr = 0;
    int          pht [2][64];
    int          ghr [2];
    int          e_en [2];
    int          e_out [2];
    int          e_ghr [2];

    always #5 clk = ~clk;

    branch_predictor_gshare #(.USE_GSHARE(1)) dut_g (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .query_en(qen), .query_pc(qpc),
        .data_out_en(en_g), .data_out(out_g), .data_out_ghr(ghr_g),
        .update_en(uen), .update_pc(upc), .update_taken(ut), .update_ghr(ughr),
        .update_mispredict(um));

    branch_predictor_gshare #(.USE_GSHARE(0)) dut_b (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .query_en(qen), .query_pc(qpc),
        .data_out_en(en_b), .data_out(out_b), .data_out_ghr(ghr_b),
        .update_en(uen), .update_pc(upc), .update_taken(ut), .update_ghr(ughr),
        .update_mispredict(um));

    task automatic chk(input string n, input int a, input int e);
        nvec++;
        if (a != e) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
        end
    endtask

    function automatic int ix(input logic [31:0] pc, input int h, input int k);
        return ((pc >> 2) % 64) ^ (k == 0 ? h : 0);
    endfunction

    // k = 0 models the gshare instance, k = 1 the bimodal one
    task automatic model_step();
        int c, i;
        bit rep;
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                for (int j = 0; j < 64; j++) pht[k][j] = 1;
                ghr[k] = 0; e_en[k] = 0; e_out[k] = 0; e_ghr[k] = 0;
            end else if (rdy) begin
                rep = uen && um;
                if (qen && !rep) begin
                    c = pht[k][ix(qpc, ghr[k], k)];
                    e_out[k] = (c >= 2) ? 1 : 0;
                    e_ghr[k] = ghr[k];
                    e_en[k] = 1;
                    ghr[k] = (ghr[k] * 2 + e_out[k]) % 16;
                end else begin
                    e_en[k] = 0;
                end
                if (uen) begin
                    i = ix(upc, int'(ughr), k);
                    c = pht[k][i];
                    pht[k][i] = ut ? (c < 3 ? c + 1 : 3) : (c > 0 ? c - 1 : 0);
                end
                if (rep) ghr[k] = (int'(ughr) * 2 + int'(ut)) % 16;
            end
        end
    endtask

    task automatic cyc(input bit q, input logic [31:0] qp, input bit u, input logic [31:0] up,
                       input bit t, input logic [3:0] ug, input bit m);
        qen = q; qpc = qp; uen = u; upc = up; ut = t; ughr = ug; um = m;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        chk("en_g", en_g, e_en[0]);
        chk("out_g", out_g, e_out[0]);
        chk("ghr_g", ghr_g, e_ghr[0]);
        chk("en_b", en_b, e_en[1]);
        chk("out_b", out_b, e_out[1]);
        chk("ghr_b", ghr_b, e_ghr[1]);
    end

    initial begin
        int r;
        rst = 0;
        cyc(1, 32'h100, 1, 32'h100, 1, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("lit_rst_en", en_g, 0);
        chk("lit_rst_out", out_g, 0);
        chk("lit_rst_ghr", ghr_g, 0);
        rst = 1;
        cyc(1, 32'h100, 0, 0, 0, 0, 0);
        chk("lit_q_en", en_g, 1);
        chk("lit_q_out", out_g, 0);
        chk("lit_q_ghr", ghr_g, 0);
        // bimodal saturation on pc 0x40
        repeat (3) cyc(0, 0, 1, 32'h40, 1, 0, 0);
        cyc(1, 32'h40, 0, 0, 0, 0, 0);
        chk("lit_sat_hi", out_b, 1);
        chk("mdl_sat_hi", e_out[1], 1);
        repeat (2) cyc(0, 0, 1, 32'h40, 1, 0, 0);
        cyc(0, 0, 1, 32'h40, 0, 0, 0);
        cyc(1, 32'h40, 0, 0, 0, 0, 0);
        chk("lit_sat_2", out_b, 1);
        repeat (2) cyc(0, 0, 1, 32'h40, 0, 0, 0);
        cyc(1, 32'h40, 0, 0, 0, 0, 0);
        chk("lit_sat_0", out_b, 0);
        chk("mdl_sat_0", e_out[1], 0);
        // gshare aliasing split on pc 0x100
        repeat (2) cyc(0, 0, 1, 32'h100, 1, 0, 0);
        cyc(0, 0, 1, 32'h3C, 0, 4'b0000, 1);
        cyc(1, 32'h100, 0, 0, 0, 0, 0);
        chk("lit_alias_t", out_g, 1);
        chk("lit_alias_tg", ghr_g, 0);
        cyc(1, 32'h100, 1, 32'h3C, 1, 4'b0010, 1);
        chk("lit_repair_en", en_g, 0);
        cyc(1, 32'h100, 0, 0, 0, 0, 0);
        chk("lit_alias_nt", out_g, 0);
        chk("lit_repair_ghr", ghr_g, 5);
        chk("mdl_repair_ghr", e_ghr[0], 5);
        // pause: entry 5 must not be trained, GHR must not shift
        rdy = 0;
        repeat (3) cyc(1, 32'h3C, 1, 32'h100, 1, 4'b0101, 0);
        chk("lit_pause_en", en_g, 1);
        rdy = 1;
        cyc(1, 32'h3C, 0, 0, 0, 0, 0);
        chk("lit_pause_q_en", en_g, 1);
        chk("lit_pause_q_out", out_g, 0);
        chk("lit_pause_q_ghr", ghr_g, 4'hA);
        // reset mid-operation
        cyc(1, 32'h80, 0, 0, 0, 0, 0);
        rst = 0;
        cyc(1, 32'h80, 0, 0, 0, 0, 0);
        chk("lit_midrst_en", en_g, 0);
        rst = 1;
        cyc(0, 0, 1, 32'h100, 0, 0, 0);
        cyc(1, 32'h100, 0, 0, 0, 0, 0);
        chk("lit_midrst_cnt", out_g, 0);
        for (int a = 0; a < 64; a++) cyc(1, a * 4, 0, 0, 0, 0, 0);
        // random traffic on a 16-entry window with junk upper/lower PC bits
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom % 100) != 0;
            rdy = ($urandom % 10) != 0;
            r = $urandom;
            cyc($urandom % 2, $urandom & 32'hFFFF_003F, ($urandom % 3) != 0,
                r & 32'hFFFF_003F, $urandom % 2, $urandom % 16, ($urandom % 4) == 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
